// File: rtl/lsu_mem_port_pkg.sv
// lsu_pkg: shared constants and types for the load/store memory port.
// Holds MemOp (funct3) encodings, the FSM state type and the default timeout.
package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_t;

    localparam int LSU_TIMEOUT_DEFAULT = 255;

    // Halfwords need addr[0]=0; words (and the encodings that act as W)
    // need addr[1:0]=0; bytes are always aligned.
    function automatic logic is_misaligned(
        input logic [2:0] op,
        input logic [1:0] a
    );
        logic mis;
        unique case (op)
            MEMOP_B, MEMOP_BU: mis = 1'b0;
            MEMOP_H, MEMOP_HU: mis = a[0];
            MEMOP_W:           mis = (a != 2'b00);
            default:           mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// lsu_mem_if: word-wide data memory bus with valid/ready handshake.
// master = load/store port, slave = memory. m_rdata valid with m_ready.
interface lsu_mem_if;

    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic        m_ready;
    logic [31:0] m_rdata;

    modport master (
        output m_valid, m_we, m_addr, m_be, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_we, m_addr, m_be, m_wdata,
        output m_ready, m_rdata
    );

endinterface

// File: rtl/lsu_mem_port_lane.sv
// lsu_lane: combinational byte-lane steering for the load/store port.
// In: mem_op, addr_lo, wdata, m_rdata. Out: be, wdata_rep, rdata_ext.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [2:0]  mem_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] m_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        unique case (addr_lo)
            2'd0:    rbyte = m_rdata[7:0];
            2'd1:    rbyte = m_rdata[15:8];
            2'd2:    rbyte = m_rdata[23:16];
            default: rbyte = m_rdata[31:24];
        endcase
        // addr[0] is ignored for halfwords: access is forced aligned
        rhalf = addr_lo[1] ? m_rdata[31:16] : m_rdata[15:0];
    end

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        rdata_ext = m_rdata;
        unique case (mem_op)
            MEMOP_B, MEMOP_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (mem_op == MEMOP_B)
                          ? {{24{rbyte[7]}}, rbyte}
                          : {24'd0, rbyte};
            end
            MEMOP_H, MEMOP_HU: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (mem_op == MEMOP_H)
                          ? {{16{rhalf[15]}}, rhalf}
                          : {16'd0, rhalf};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = m_rdata;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: one handshaked load/store per req on a word memory bus.
// Ports: clk, rst (async active-low); req/we/mem_op/addr/wdata in;
// busy/done/err/rdata out; mem = lsu_mem_if.master bus.
// TIMEOUT bounds ACCESS wait cycles (0 = no limit).
// LSU_MISALIGN_TRAP_EN: misaligned H/W requests finish with err, no bus cycle.
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    lsu_mem_if.master   mem
);

    localparam logic [1:0] S_IDLE   = LSU_IDLE;
    localparam logic [1:0] S_ACCESS = LSU_ACCESS;
    localparam logic [1:0] S_DONE   = LSU_DONE;

    // Counter only needs to reach TIMEOUT-1
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;

    logic [3:0]    lane_be;
    logic [31:0]   lane_wdata;
    logic [31:0]   lane_rdata;
    logic          tmo_hit;

    lsu_lane u_lane (
        .mem_op    (op_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .m_rdata   (mem.m_rdata),
        .be        (lane_be),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    op_d    = mem_op;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_ACCESS;
`ifdef LSU_MISALIGN_TRAP_EN
                    if (is_misaligned(mem_op, addr[1:0])) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            S_ACCESS: begin
                // A ready in the timeout cycle still completes normally
                if (mem.m_ready) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = lane_rdata;
                    end
                end else if (tmo_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            op_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign err   = err_q;
    assign rdata = rdata_q;

    // Bus fields come from the registered request, so they hold in ACCESS
    assign mem.m_valid = (state_q == S_ACCESS);
    assign mem.m_we    = (state_q == S_ACCESS) && we_q;
    assign mem.m_addr  = {addr_q[31:2], 2'b00};
    assign mem.m_be    = (state_q == S_ACCESS) ? lane_be : 4'b0000;
    assign mem.m_wdata = lane_wdata;

endmodule
